// File: rtl/uart_tx.sv
// uart_tx -- self-contained UART transmitter that repeats the ROM message
// "HELLO\r\n" (0x48 0x45 0x4C 0x4C 0x4F 0x0D 0x0A) forever, gated by CTS.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (async assert, sync release
//                   is the responsibility of the reset source)
//   UARTn_CTS  in   clear-to-send, active high, asynchronous to clk
//   UARTn_TXD  out  serial line, idles high, 8N1 LSB first (registered)
//
// Parameters:
//   CLK_FREQ_HZ, BAUD_RATE  -> CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (floor)
//   STOP_BITS               -> 1 or 2
//
// Optional feature macro: UART_TX_PARITY_EN
//   Defined  : an even-parity bit follows the 8 data bits (8E1 framing).
//   Undefined: plain 8N1, no parity state or logic.
//
// Flow control: CTS is a level, not a pulse. A frame may only start on a
// cycle where the synchronised CTS (cts_s) is 1; once started, a frame always
// runs to the end of its stop bit(s) regardless of CTS.
//
// The FSM state is held in state_q (type state_t) for checkers to bind to.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 150_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int STOP_BITS   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic UARTn_CTS,
  output logic UARTn_TXD
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  // Guarded so an illegal configuration still elaborates far enough to report.
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  // Shift register carries the parity bit above the data byte so the parity
  // state simply transmits bit 0 after the eighth shift.
  localparam int SW = 9;
`else
  localparam int SW = 8;
`endif

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;     // data bit index, reused as stop-bit index
  logic [2:0]      idx_q, idx_d;     // ROM index 0..6
  logic [SW-1:0]   shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            cts_meta, cts_s;
  logic            baud_done;

  function automatic logic [7:0] rom_byte(input logic [2:0] i);
    case (i)
      3'd0:    rom_byte = 8'h48;
      3'd1:    rom_byte = 8'h45;
      3'd2:    rom_byte = 8'h4C;
      3'd3:    rom_byte = 8'h4C;
      3'd4:    rom_byte = 8'h4F;
      3'd5:    rom_byte = 8'h0D;
      3'd6:    rom_byte = 8'h0A;
      default: rom_byte = 8'h48;
    endcase
  endfunction

  function automatic logic [SW-1:0] load_word(input logic [2:0] i);
    logic [7:0] b;
    b = rom_byte(i);
`ifdef UART_TX_PARITY_EN
    load_word = {^b, b};
`else
    load_word = b;
`endif
  endfunction

  // Two-flop CTS synchroniser. The if() form means an X/Z pin takes the else
  // branch in simulation, so an undriven pin is treated as not-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta <= 1'b0;
      cts_s    <= 1'b0;
    end else begin
      if (UARTn_CTS) cts_meta <= 1'b1;
      else           cts_meta <= 1'b0;
      cts_s <= cts_meta;
    end
  end

  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = 1'b1;

    case (state_q)
      IDLE: begin
        if (cts_s) begin
          state_d = START;
          shift_d = load_word(idx_q);
          baud_d  = '0;
          bit_d   = '0;
        end
      end

      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_d = STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
`endif

      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            idx_d = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
            // Back-to-back: start the next frame on this same edge, no gap.
            if (cts_s) begin
              state_d = START;
              shift_d = load_word(idx_d);
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // TXD is registered from the state being entered, so the line changes on
    // the same edge as the state.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = shift_d[0];
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign UARTn_TXD = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx (CLKS_PER_BIT = 10).
// A frame-position reference model predicts TXD on every cycle; table-driven
// frame decodes and hand-written sequences cover latency, CTS drop/resume,
// async reset and the default-parameter bit time.
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * CPB;

  logic clk = 1'b0;
  logic rst_n;
  logic cts;
  logic txd;
  logic cts_def;
  logic txd_def;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .UARTn_CTS(cts), .UARTn_TXD(txd)
  );

  uart_tx u_dut_def (
    .clk(clk), .rst_n(rst_n), .UARTn_CTS(cts_def), .UARTn_TXD(txd_def)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] msg [7] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
  logic [7:0] exp_q [$];   // bytes the model has started, in order

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  int         m_pos;    // cycles into the current frame, -1 when idle
  int         m_idx;
  logic [7:0] m_cur;
  logic       m_h1, m_h2;
  logic       m_txd;

  always @(posedge clk or negedge rst_n) begin : model
    int p;
    int ix;
    logic [7:0] c;
    if (!rst_n) begin
      m_pos <= -1;
      m_idx <= 0;
      m_cur <= 8'h00;
      m_h1  <= 1'b0;
      m_h2  <= 1'b0;
      m_txd <= 1'b1;
    end else begin
      p  = m_pos;
      ix = m_idx;
      c  = m_cur;
      if (p >= 0) begin
        p = p + 1;
        if (p == FRAME_LEN) begin
          p  = -1;
          ix = (ix + 1) % 7;
        end
      end
      // m_h2 is the pin as seen two edges ago.
      if (p < 0 && m_h2) begin
        p = 0;
        c = msg[ix];
        exp_q.push_back(c);
      end
      m_pos <= p;
      m_idx <= ix;
      m_cur <= c;
      m_txd <= (p < 0) ? 1'b1 : frame_bit(c, p / CPB);
      m_h2  <= m_h1;
      m_h1  <= (cts === 1'b1);
    end
  end

  always @(negedge clk) begin
    checks++;
    if (txd !== m_txd) begin
      errors++;
      $display("FAIL txd_model t=%0t got %b expected %b", $time, txd, m_txd);
    end
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge right after the start edge; samples mid-bit and
  // returns at the negedge FRAME_LEN cycles later. Drops CTS at drop_at.
  task automatic get_frame(input int drop_at, output logic st, output logic [7:0] b,
                           output logic par, output logic sp);
    int c;
    logic [NBITS-1:0] s;
    c = 0;
    s = '0;
    for (int k = 0; k < NBITS; k++) begin
      while (c < k * CPB + CPB / 2) begin
        @(negedge clk);
        c++;
        if (c == drop_at) cts = 1'b0;
      end
      s[k] = txd;
    end
    while (c < FRAME_LEN) begin
      @(negedge clk);
      c++;
      if (c == drop_at) cts = 1'b0;
    end
    st = s[0];
    b  = s[8:1];
`ifdef UART_TX_PARITY_EN
    par = s[9];
`else
    par = 1'b0;
`endif
    sp = s[NBITS-1];
  endtask

  task automatic expect_start(input string name);
    @(negedge clk);
    @(negedge clk);
    check({name, "_edge2"}, {7'd0, txd}, 8'd1);
    @(negedge clk);
    check({name, "_edge3"}, {7'd0, txd}, 8'd0);
  endtask

  typedef struct {
    int         drop_at;
    logic [7:0] exp_byte;
    logic       exp_par;
  } frame_vec_t;

  frame_vec_t tbl [8];

  initial begin
    logic st, par, sp, fell;
    logic [7:0] b;
    int low;

    tbl[0] = '{-1, 8'h48, 1'b0};
    tbl[1] = '{-1, 8'h45, 1'b1};
    tbl[2] = '{-1, 8'h4C, 1'b1};
    tbl[3] = '{-1, 8'h4C, 1'b1};
    tbl[4] = '{-1, 8'h4F, 1'b1};
    tbl[5] = '{-1, 8'h0D, 1'b1};
    tbl[6] = '{-1, 8'h0A, 1'b0};
    tbl[7] = '{35, 8'h48, 1'b0};

    // Reset with an undriven CTS pin.
    rst_n   = 1'b0;
    cts     = 1'bx;
    cts_def = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", {7'd0, txd}, 8'd1);
    rst_n = 1'b1;
    cts   = 1'b0;
    repeat (500) @(negedge clk);
    check("idle_no_cts", {7'd0, txd}, 8'd1);

    // CTS rise -> start bit three edges later, then 8 frames back to back.
    cts = 1'b1;
    expect_start("latency");
    for (int i = 0; i < 8; i++) begin
      get_frame(tbl[i].drop_at, st, b, par, sp);
      check($sformatf("frame%0d_start", i), {7'd0, st}, 8'd0);
      check($sformatf("frame%0d_byte", i), b, tbl[i].exp_byte);
`ifdef UART_TX_PARITY_EN
      check($sformatf("frame%0d_parity", i), {7'd0, par}, {7'd0, tbl[i].exp_par});
`endif
      check($sformatf("frame%0d_stop", i), {7'd0, sp}, 8'd1);
      if (exp_q.size() != 0) begin
        check($sformatf("frame%0d_model_byte", i), b, exp_q.pop_front());
      end
      // Back-to-back frames start exactly FRAME_LEN cycles apart.
      check($sformatf("frame%0d_next_start", i), {7'd0, txd},
            (tbl[i].drop_at < 0) ? 8'd0 : 8'd1);
    end

    // CTS was dropped mid-frame: line stays idle, then resumes at 0x45.
    repeat (200) @(negedge clk);
    check("idle_after_drop", {7'd0, txd}, 8'd1);
    cts = 1'b1;
    expect_start("resume");
    get_frame(-1, st, b, par, sp);
    check("resume_byte", b, 8'h45);
    check("resume_stop", {7'd0, sp}, 8'd1);

    // Async reset mid-frame of 0x4C: line returns high without a clock edge.
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_txd", {7'd0, txd}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_start("after_reset");
    get_frame(-1, st, b, par, sp);
    check("after_reset_byte", b, 8'h48);

    // Random CTS activity, judged cycle-by-cycle against the model.
    repeat (12) begin
      cts = 1'($urandom_range(0, 1));
      repeat ($urandom_range(5, 400)) @(negedge clk);
    end
    cts = 1'b0;
    repeat (FRAME_LEN + 10) @(negedge clk);
    check("final_idle", {7'd0, txd}, 8'd1);

    // Default parameters: 0x48 starts with start bit + three 0 data bits.
    cts_def = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 10 && !fell; i++) begin
      @(negedge clk);
      if (!txd_def) fell = 1'b1;
    end
    check("def_start_fall", {7'd0, fell}, 8'd1);
    low = 0;
    while (txd_def == 1'b0 && low < 70000) begin
      @(negedge clk);
      low++;
    end
    check_int("def_low_len", low, 4 * 15625);
    cts_def = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
